// File: rtl/trace_pkg.sv
// Shared retire-trace types: instruction kind encoding, record layout and field widths.
package trace_pkg;

  localparam int KIND_W     = 4;
  localparam int FIELD_W    = 16;
  localparam int KIND_COUNT = 9;
  localparam int REC_W      = KIND_W + 3 * FIELD_W;

  typedef enum logic [KIND_W-1:0] {
    KIND_SUB  = 4'd0,
    KIND_MOVL = 4'd1,
    KIND_MOVH = 4'd2,
    KIND_LD   = 4'd3,
    KIND_ST   = 4'd4,
    KIND_JZ   = 4'd5,
    KIND_JNZ  = 4'd6,
    KIND_JS   = 4'd7,
    KIND_JNS  = 4'd8
  } traceKind_t;

  // addr: reg index / mem addr / jump target; data: written value / taken flag.
  typedef struct packed {
    logic [KIND_W-1:0]  kind;
    logic [FIELD_W-1:0] pc;
    logic [FIELD_W-1:0] addr;
    logic [FIELD_W-1:0] data;
  } traceRec_t;

  // Undefined kind codes (9..15) are never recorded, whatever the mask says.
  function automatic logic kindEnabled(input logic [KIND_W-1:0] kind,
                                       input logic [KIND_COUNT-1:0] mask);
    logic [15:0] maskExt;
    maskExt = 16'(mask);
    return (kind < KIND_W'(KIND_COUNT)) && maskExt[kind];
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: DEPTH x REC_W, one write port per retire lane, one asynchronous read port.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int LANES  = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic [LANES-1:0]        wrEn,
  input  logic [LANES*ADDR_W-1:0] wrAddr,
  input  logic [LANES*REC_W-1:0]  wrData,
  input  logic [ADDR_W-1:0]       rdAddr,
  output logic [REC_W-1:0]        rdData
);

  logic [REC_W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; occupancy lives in the pointers and count,
  // so stale contents are never observed and the storage can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wrEn[i]) begin
        mem[wrAddr[i*ADDR_W +: ADDR_W]] <= wrData[i*REC_W +: REC_W];
      end
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace FIFO: filters retiring instructions by kind, stores them in order,
// and lets a consumer drain the oldest record, in either stop-when-full or overwrite mode.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int LANES = 1,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture_en,
  input  logic                  wrap_mode,
  input  logic [KIND_COUNT-1:0] kind_mask,
  input  logic                  halt,
  input  logic [LANES-1:0]      ret_valid,
  input  logic [4*LANES-1:0]    ret_kind,
  input  logic [16*LANES-1:0]   ret_pc,
  input  logic [16*LANES-1:0]   ret_addr,
  input  logic [16*LANES-1:0]   ret_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_kind,
  output logic [15:0]           out_pc,
  output logic [15:0]           out_addr,
  output logic [15:0]           out_data,
  output logic [CNT_W-1:0]      count,
  output logic [15:0]           lost,
  output logic                  halted
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]       headPtr;
  logic [PTR_W-1:0]       tailPtr;
  logic [CNT_W-1:0]       countQ;
  logic [15:0]            lostQ;
  logic                   haltedQ;

  logic [LANES-1:0]       wrEn;
  logic [LANES*PTR_W-1:0] wrAddr;
  logic [LANES*REC_W-1:0] wrData;
  logic [REC_W-1:0]       headRaw;
  traceRec_t              headRec;
  traceRec_t              laneRec;

  logic [CNT_W-1:0]       freeSlots;
  logic [CNT_W-1:0]       accepted;
  logic [1:0]             rejected;
  logic                   pop;
  logic [CNT_W:0]         total;
  logic [CNT_W:0]         overwritten;
  logic [16:0]            lostSum;

  // A full buffer has count == DEPTH, whose low bits are zero, so tail lands back on head.
  assign tailPtr = headPtr + countQ[PTR_W-1:0];
  assign pop     = (countQ != '0) && out_ready;

  // Eligible lanes are compacted into consecutive slots from the tail, lane 0 first.
  // NOTE: every signal written here gets a default before the loop so no path infers a latch.
  always_comb begin
    freeSlots = CNT_W'(DEPTH) - countQ;
    accepted  = '0;
    rejected  = '0;
    wrEn      = '0;
    wrAddr    = '0;
    wrData    = '0;
    laneRec   = '0;
    for (int i = 0; i < LANES; i++) begin
      laneRec.kind = ret_kind[4*i +: 4];
      laneRec.pc   = ret_pc[16*i +: 16];
      laneRec.addr = ret_addr[16*i +: 16];
      laneRec.data = ret_data[16*i +: 16];
      wrData[i*REC_W +: REC_W] = laneRec;
      wrAddr[i*PTR_W +: PTR_W] = tailPtr + accepted[PTR_W-1:0];
      if (ret_valid[i] && capture_en && !haltedQ && kindEnabled(laneRec.kind, kind_mask)) begin
        if (wrap_mode || (accepted < freeSlots)) begin
          wrEn[i]  = !reset;
          accepted = accepted + 1'b1;
        end else begin
          rejected = rejected + 1'b1;
        end
      end
    end
  end

  // Stop mode never accepts past DEPTH, so overwritten is only ever non-zero in wrap mode.
  always_comb begin
    total       = {1'b0, countQ} - (CNT_W+1)'(pop) + {1'b0, accepted};
    overwritten = (total > (CNT_W+1)'(DEPTH)) ? total - (CNT_W+1)'(DEPTH) : '0;
    lostSum     = 17'(lostQ) + 17'(rejected) + 17'(overwritten);
  end

  // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr <= '0;
      countQ  <= '0;
      lostQ   <= '0;
      haltedQ <= 1'b0;
    end else begin
      headPtr <= headPtr + PTR_W'(pop) + overwritten[PTR_W-1:0];
      countQ  <= countQ + accepted - CNT_W'(pop) - overwritten[CNT_W-1:0];
      lostQ   <= lostSum[16] ? 16'hFFFF : lostSum[15:0];
      if (halt) begin
        haltedQ <= 1'b1;
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .LANES (LANES),
    .ADDR_W(PTR_W)
  ) uRam (
    .clk   (clk),
    .wrEn  (wrEn),
    .wrAddr(wrAddr),
    .wrData(wrData),
    .rdAddr(headPtr),
    .rdData(headRaw)
  );

  assign headRec   = traceRec_t'(headRaw);
  assign out_valid = (countQ != '0);
  assign out_kind  = headRec.kind;
  assign out_pc    = headRec.pc;
  assign out_addr  = headRec.addr;
  assign out_data  = headRec.data;
  assign count     = countQ;
  assign lost      = lostQ;
  assign halted    = haltedQ;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: a single-lane and a dual-lane instance share stimulus and are
// each scored against a queue-based reference model of the trace rules.
module tb_retire_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        reset, capture_en, wrap_mode, halt, out_ready;
  logic [8:0]  kind_mask;
  logic [1:0]  ret_valid;
  logic [7:0]  ret_kind;
  logic [31:0] ret_pc, ret_addr, ret_data;

  logic             a_out_valid, b_out_valid, a_halted, b_halted;
  logic [3:0]       a_out_kind, b_out_kind;
  logic [15:0]      a_out_pc, a_out_addr, a_out_data, b_out_pc, b_out_addr, b_out_data;
  logic [15:0]      a_lost, b_lost;
  logic [CNT_W-1:0] a_count, b_count;

  always #5 clk = ~clk;

  retire_trace_buffer #(.LANES(1), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .reset(reset), .capture_en(capture_en), .wrap_mode(wrap_mode),
    .kind_mask(kind_mask), .halt(halt), .ret_valid(ret_valid[0:0]), .ret_kind(ret_kind[3:0]),
    .ret_pc(ret_pc[15:0]), .ret_addr(ret_addr[15:0]), .ret_data(ret_data[15:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_kind(a_out_kind), .out_pc(a_out_pc),
    .out_addr(a_out_addr), .out_data(a_out_data), .count(a_count), .lost(a_lost),
    .halted(a_halted)
  );

  retire_trace_buffer #(.LANES(2), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .reset(reset), .capture_en(capture_en), .wrap_mode(wrap_mode),
    .kind_mask(kind_mask), .halt(halt), .ret_valid(ret_valid), .ret_kind(ret_kind),
    .ret_pc(ret_pc), .ret_addr(ret_addr), .ret_data(ret_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_kind(b_out_kind), .out_pc(b_out_pc),
    .out_addr(b_out_addr), .out_data(b_out_data), .count(b_count), .lost(b_lost),
    .halted(b_halted)
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference state per instance: index 0 = single lane, 1 = dual lane.
  traceRec_t mq[2][$];
  int        mlost[2];
  bit        mhalt[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trace rules in queue form: pop the head, append accepted records, trim the oldest past DEPTH.
  task automatic model_step(input int inst, input int lanes);
    int n0;
    int acc;
    traceRec_t r;
    bit elig;
    if (reset) begin
      mq[inst].delete();
      mlost[inst] = 0;
      mhalt[inst] = 1'b0;
      return;
    end
    n0  = mq[inst].size();
    acc = 0;
    if (out_ready && n0 > 0) void'(mq[inst].pop_front());
    for (int i = 0; i < lanes; i++) begin
      r.kind = ret_kind[4*i +: 4];
      r.pc   = ret_pc[16*i +: 16];
      r.addr = ret_addr[16*i +: 16];
      r.data = ret_data[16*i +: 16];
      elig = ret_valid[i] && capture_en && !mhalt[inst] && (r.kind <= 4'd8) && kind_mask[r.kind];
      if (elig) begin
        if (wrap_mode || (n0 + acc < DEPTH)) begin
          mq[inst].push_back(r);
          acc++;
        end else begin
          mlost[inst]++;
        end
      end
    end
    if (wrap_mode) begin
      while (mq[inst].size() > DEPTH) begin
        void'(mq[inst].pop_front());
        mlost[inst]++;
      end
    end
    if (mlost[inst] > 65535) mlost[inst] = 65535;
    if (halt) mhalt[inst] = 1'b1;
  endtask

  always @(posedge clk) begin
    model_step(0, 1);
    model_step(1, 2);
  end

  task automatic mon_check(input int inst, input logic v, input logic [3:0] k,
                           input logic [15:0] pc, input logic [15:0] addr, input logic [15:0] data,
                           input logic [CNT_W-1:0] cnt, input logic [15:0] lst, input logic h);
    string tag;
    tag = (inst == 0) ? "lane1" : "lane2";
    check({tag, "_count"}, 64'(cnt), 64'(mq[inst].size()));
    check({tag, "_valid"}, 64'(v), 64'(mq[inst].size() != 0));
    check({tag, "_lost"}, 64'(lst), 64'(mlost[inst]));
    check({tag, "_halted"}, 64'(h), 64'(mhalt[inst]));
    if (mq[inst].size() != 0) check({tag, "_head"}, 64'({k, pc, addr, data}), 64'(mq[inst][0]));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_check(0, a_out_valid, a_out_kind, a_out_pc, a_out_addr, a_out_data, a_count, a_lost, a_halted);
      mon_check(1, b_out_valid, b_out_kind, b_out_pc, b_out_addr, b_out_data, b_count, b_lost, b_halted);
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    ret_valid = 2'b00;
    out_ready = 1'b0;
    halt      = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic retire1(input logic [3:0] k, input logic [15:0] pc,
                         input logic [15:0] addr, input logic [15:0] data);
    ret_valid      = 2'b01;
    ret_kind[3:0]  = k;
    ret_pc[15:0]   = pc;
    ret_addr[15:0] = addr;
    ret_data[15:0] = data;
    tick();
    ret_valid = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; capture_en = 1'b0; wrap_mode = 1'b0; halt = 1'b0; out_ready = 1'b0;
    kind_mask = 9'h1FF; ret_valid = 2'b00; ret_kind = '0;
    ret_pc = '0; ret_addr = '0; ret_data = '0;
    do_reset();
    mon_en = 1'b1;
    check("reset_count", 64'(b_count), 64'd0);
    check("reset_valid", 64'(b_out_valid), 64'd0);
    check("reset_lost", 64'(b_lost), 64'd0);
    check("reset_halted", 64'(b_halted), 64'd0);

    // Stop mode: six movl into four slots keeps the first four.
    capture_en = 1'b1;
    for (int i = 0; i < 6; i++) retire1(KIND_MOVL, 16'(i), 16'd1, 16'(i));
    check("stop_count", 64'(a_count), 64'd4);
    check("stop_lost", 64'(a_lost), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stop_drain_pc", 64'(a_out_pc), 64'(i));
      tick();
    end
    out_ready = 1'b0;
    check("stop_drained", 64'(a_out_valid), 64'd0);

    // Wrap mode: same stimulus keeps the newest four.
    do_reset();
    wrap_mode = 1'b1;
    for (int i = 0; i < 6; i++) retire1(KIND_MOVL, 16'(i), 16'd1, 16'(i));
    check("wrap_count", 64'(a_count), 64'd4);
    check("wrap_lost", 64'(a_lost), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("wrap_drain_pc", 64'(a_out_pc), 64'(i + 2));
      tick();
    end
    out_ready = 1'b0;

    // Dual lane with one free slot in stop mode: lane 0 fits, lane 1 is lost.
    do_reset();
    wrap_mode = 1'b0;
    for (int i = 0; i < 3; i++) retire1(KIND_MOVL, 16'h20 + 16'(i), 16'd2, 16'd0);
    check("dual_pre_count", 64'(b_count), 64'd3);
    ret_valid = 2'b11; ret_kind = {KIND_MOVL, KIND_MOVL};
    ret_pc = {16'h0024, 16'h0023}; ret_addr = {16'd5, 16'd4}; ret_data = 32'h0;
    tick();
    ret_valid = 2'b00;
    check("dual_count", 64'(b_count), 64'd4);
    check("dual_lost", 64'(b_lost), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("dual_drain_pc", 64'(b_out_pc), 64'h20 + 64'(i));
      tick();
    end
    out_ready = 1'b0;

    // Kind filter: only the store passes a mask of 9'h010.
    do_reset();
    kind_mask = 9'h010;
    retire1(KIND_SUB, 16'h0100, 16'd1, 16'h0007);
    retire1(KIND_ST,  16'h0101, 16'h0040, 16'h1234);
    retire1(KIND_JZ,  16'h0102, 16'h0200, 16'h0001);
    check("mask_count", 64'(b_count), 64'd1);
    check("mask_lost", 64'(b_lost), 64'd0);
    check("mask_kind", 64'(b_out_kind), 64'(KIND_ST));
    check("mask_addr", 64'(b_out_addr), 64'h0040);
    check("mask_data", 64'(b_out_data), 64'h1234);
    kind_mask = 9'h1FF;

    // Halt: the same-cycle load is kept, later retirements are ignored, draining still works.
    do_reset();
    halt = 1'b1;
    retire1(KIND_LD, 16'h0200, 16'd3, 16'h00FF);
    halt = 1'b0;
    check("halt_flag", 64'(b_halted), 64'd1);
    check("halt_count", 64'(b_count), 64'd1);
    retire1(KIND_MOVL, 16'h0201, 16'd1, 16'h0001);
    retire1(KIND_ST,   16'h0202, 16'd1, 16'h0002);
    check("halt_ignored", 64'(b_count), 64'd1);
    check("halt_lost", 64'(b_lost), 64'd0);
    check("halt_data", 64'(b_out_data), 64'h00FF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("halt_drained", 64'(b_count), 64'd0);
    check("halt_sticky", 64'(b_halted), 64'd1);

    // Full wrap buffer with simultaneous push and pop: occupancy and loss unchanged.
    do_reset();
    wrap_mode = 1'b1;
    for (int i = 0; i < 4; i++) retire1(KIND_MOVH, 16'h30 + 16'(i), 16'd6, 16'(i));
    check("pp_full", 64'(b_count), 64'd4);
    ret_valid = 2'b01; ret_kind[3:0] = KIND_MOVH; ret_pc[15:0] = 16'h0034;
    out_ready = 1'b1;
    check("pp_old_head", 64'(b_out_pc), 64'h30);
    tick();
    ret_valid = 2'b00; out_ready = 1'b0;
    check("pp_count", 64'(b_count), 64'd4);
    check("pp_lost", 64'(b_lost), 64'd0);
    check("pp_new_head", 64'(b_out_pc), 64'h31);

    // Randomized traffic scored by the monitor.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      halt  = ($urandom_range(0, 499) == 0);
      if (c % 48 == 0) begin
        wrap_mode = 1'($urandom_range(0, 1));
        kind_mask = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h1FF;
      end
      capture_en = ($urandom_range(0, 9) != 0);
      out_ready  = 1'($urandom_range(0, 1));
      ret_valid  = 2'($urandom);
      for (int l = 0; l < 2; l++) begin
        ret_kind[4*l +: 4]  = 4'($urandom_range(0, 10));
        ret_pc[16*l +: 16]  = 16'($urandom);
        ret_addr[16*l +: 16] = 16'($urandom);
        ret_data[16*l +: 16] = 16'($urandom);
      end
      tick();
    end
    reset = 1'b0; halt = 1'b0; ret_valid = 2'b00; out_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
